// File: rtl/voice_env_pwm_mixer.sv
// Five-voice mixer: per-voice retriggered linear-decay envelopes, weighted
// sum of the square-wave bits, and a single-bit PWM for the speaker pin.
// Also reports per-voice envelope activity for the LED bar.
module voice_env_pwm_mixer #(
  parameter int DECAY_DIV  = 2000,
  parameter int PWM_PERIOD = 1275
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [4:0]  WAVE,
  input  logic [34:0] TONES,
  output logic        PWM_OUT,
  output logic [4:0]  ACTIVE,
  output logic [10:0] LEVEL
);

  localparam logic [15:0] DIV_LAST_C = 16'(DECAY_DIV - 1);
  localparam logic [10:0] PC_LAST_C  = 11'(PWM_PERIOD - 1);

  logic [4:0][6:0] tone_s;
  logic [4:0][6:0] prev_tone_r;
  logic [4:0]      onset_s;
  logic [4:0][7:0] env_r;
  logic [4:0][7:0] env_next_s;
  logic [4:0]      active_r;
  logic [15:0]     presc_r;
  logic            tick_s;
  logic [10:0]     mix_s;
  logic [10:0]     mix_r;
  logic [10:0]     pc_r;
  logic [10:0]     pc_next_s;
  logic [10:0]     level_r;
  logic [10:0]     level_next_s;
  logic            pwm_r;

  assign tick_s = (presc_r == DIV_LAST_C);

  // Split tones per voice, detect onsets and pick each envelope's next value
  // (rest clear beats onset, onset beats decay).
  always_comb begin
    tone_s     = '0;
    onset_s    = '0;
    env_next_s = env_r;
    for (int i = 0; i < 5; i++) begin
      tone_s[i]  = TONES[7*i +: 7];
      onset_s[i] = (tone_s[i] != prev_tone_r[i]) && (tone_s[i] != 7'd0);
      if (tone_s[i] == 7'd0) begin
        env_next_s[i] = 8'd0;
      end else if (onset_s[i]) begin
        env_next_s[i] = 8'd255;
      end else if (tick_s && EN && (env_r[i] != 8'd0)) begin
        env_next_s[i] = env_r[i] - 8'd1;
      end else begin
        env_next_s[i] = env_r[i];
      end
    end
  end

  // Weighted sum of the voices whose square-wave bit is currently high.
  always_comb begin
    mix_s = 11'd0;
    for (int i = 0; i < 5; i++) begin
      if (WAVE[i]) begin
        mix_s = mix_s + {3'b000, env_r[i]};
      end else begin
        mix_s = mix_s;
      end
    end
  end

  // Frame counter advance; the level for the next frame is taken at the wrap.
  always_comb begin
    pc_next_s    = pc_r + 11'd1;
    level_next_s = level_r;
    if (pc_r == PC_LAST_C) begin
      pc_next_s    = 11'd0;
      level_next_s = mix_r;
    end else begin
      pc_next_s    = pc_r + 11'd1;
      level_next_s = level_r;
    end
  end

  // Tone history, envelopes and activity flags (history tracks even when disabled).
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_tone_r <= '0;
      env_r       <= '0;
      active_r    <= 5'd0;
    end else begin
      prev_tone_r <= tone_s;
      env_r       <= env_next_s;
      for (int i = 0; i < 5; i++) begin
        active_r[i] <= (env_r[i] != 8'd0);
      end
    end
  end

  // Decay prescaler: free-runs while enabled, frozen otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_r <= 16'd0;
    end else if (EN) begin
      if (tick_s) begin
        presc_r <= 16'd0;
      end else begin
        presc_r <= presc_r + 16'd1;
      end
    end else begin
      presc_r <= presc_r;
    end
  end

  // Mix sample, PWM frame counter, latched level and output bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mix_r   <= 11'd0;
      pc_r    <= 11'd0;
      level_r <= 11'd0;
      pwm_r   <= 1'b0;
    end else begin
      mix_r   <= mix_s;
      pc_r    <= pc_next_s;
      level_r <= level_next_s;
      pwm_r   <= EN && (pc_next_s < level_next_s);
    end
  end

  assign PWM_OUT = pwm_r;
  assign ACTIVE  = active_r;
  assign LEVEL   = level_r;

endmodule

// File: tb/tb_voice_env_pwm_mixer.sv
// Directed bench for voice_env_pwm_mixer: a vector table for retrigger/rest/
// enable rules on a fast-decay instance, plus hand-timed multi-frame sequences.
module tb_voice_env_pwm_mixer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [4:0]  WAVE;
  logic [34:0] TONES;
  logic        pwm0, pwm1;
  logic [4:0]  act0, act1;
  logic [10:0] lvl0, lvl1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  voice_env_pwm_mixer #(.DECAY_DIV(4), .PWM_PERIOD(1275)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .WAVE(WAVE), .TONES(TONES),
    .PWM_OUT(pwm0), .ACTIVE(act0), .LEVEL(lvl0)
  );

  voice_env_pwm_mixer #(.DECAY_DIV(1), .PWM_PERIOD(1275)) dut1 (
    .CLK(CLK), .RST(RST), .EN(EN), .WAVE(WAVE), .TONES(TONES),
    .PWM_OUT(pwm1), .ACTIVE(act1), .LEVEL(lvl1)
  );

  typedef struct {
    logic       en;
    logic [6:0] tone2;
    int         hold;
    logic [7:0] exp_env;
    logic       exp_act;
  } vec_t;

  vec_t vecs [11];

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; WAVE = 5'd0; TONES = 35'd0;
    step(2);
    RST = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    int lvl;
    int fall;

    RST = 1'b1; EN = 1'b0; WAVE = 5'd0; TONES = 35'd0;

    // en, tone2, hold, exp_env, exp_act   (DECAY_DIV=1 instance, voice 2)
    vecs[0]  = '{1'b1, 7'd40,  1, 8'd255, 1'b0};
    vecs[1]  = '{1'b1, 7'd40,  1, 8'd254, 1'b1};
    vecs[2]  = '{1'b1, 7'd40, 98, 8'd156, 1'b1};
    vecs[3]  = '{1'b1, 7'd41,  1, 8'd255, 1'b1};
    vecs[4]  = '{1'b1, 7'd41,  1, 8'd254, 1'b1};
    vecs[5]  = '{1'b1, 7'd0,   1, 8'd0,   1'b1};
    vecs[6]  = '{1'b1, 7'd0,   1, 8'd0,   1'b0};
    vecs[7]  = '{1'b0, 7'd60,  1, 8'd255, 1'b0};
    vecs[8]  = '{1'b0, 7'd60, 50, 8'd255, 1'b1};
    vecs[9]  = '{1'b1, 7'd60, 10, 8'd245, 1'b1};
    vecs[10] = '{1'b0, 7'd0,   1, 8'd0,   1'b1};

    // Reset with everything playing: outputs stay zero, then all voices retrigger.
    RST = 1'b1; EN = 1'b1; WAVE = 5'h1F; TONES = {5{7'd30}};
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("reset_outs_div4", {pwm0, act0, lvl0}, 0);
      check("reset_outs_div1", {pwm1, act1, lvl1}, 0);
    end
    RST = 1'b0;
    step(2);
    check("reset_release_active", act0, 31);
    for (int v = 0; v < 5; v++) check("reset_release_env", dut.env_r[v], 255);

    // Full mix: onset with EN low, enable just before the wrap.
    do_reset();
    WAVE = 5'h1F; TONES = {5{7'd30}};
    step(1274);
    EN = 1'b1;
    hi_cnt = 0;
    for (int k = 0; k < 1275; k++) begin
      step(1);
      if (k == 0) check("full_level", lvl0, 1275);
      if (k == 1) WAVE = 5'd0;
      if (pwm0) hi_cnt++;
    end
    check("full_pwm_high_cycles", hi_cnt, 1275);
    hi_cnt = 0;
    for (int k = 0; k < 1275; k++) begin
      step(1);
      if (k == 0) check("zero_level", lvl0, 0);
      if (pwm0) hi_cnt++;
    end
    check("zero_pwm_high_cycles", hi_cnt, 0);

    // Single voice, onset landing on a prescaler tick just before the wrap.
    do_reset();
    EN = 1'b1; WAVE = 5'b00001;
    step(1271);
    TONES = 35'd30;
    step(1);
    check("onset_beats_tick_env", dut.env_r[0], 255);
    step(1);
    check("single_active0", act0[0], 1);
    step(2);
    check_range("single_level", lvl0, 254, 255);
    lvl = lvl0;
    hi_cnt = 0;
    fall = -1;
    for (int k = 0; k < 1275; k++) begin
      if (k != 0) step(1);
      if (pwm0) hi_cnt++;
      if (fall < 0 && !act0[0]) fall = 1275 + k - 1272;
    end
    check("single_pwm_high_cycles", hi_cnt, lvl);
    check_range("single_active_fall", fall, 1016, 1024);

    // Retrigger / rest / enable rules on the DECAY_DIV=1 instance.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      EN = vecs[i].en;
      TONES = 35'(vecs[i].tone2) << 14;
      step(vecs[i].hold);
      check($sformatf("vec%0d_env2", i), dut1.env_r[2], vecs[i].exp_env);
      check($sformatf("vec%0d_active", i), act1, {2'b00, vecs[i].exp_act, 2'b00});
    end

    // EN gating mid-decay with a nonzero latched level.
    do_reset();
    EN = 1'b1; WAVE = 5'b00001;
    step(1200);
    TONES = 35'd30;
    step(80);
    check("gate_level", lvl0, 237);
    check("gate_env_before", dut.env_r[0], 235);
    EN = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 500; k++) begin
      step(1);
      if (pwm0) hi_cnt++;
    end
    check("gate_pwm_high_cycles", hi_cnt, 0);
    check("gate_env_held", dut.env_r[0], 235);
    EN = 1'b1;
    step(3);
    check("resume_env_pre_tick", dut.env_r[0], 235);
    step(1);
    check("resume_env_tick", dut.env_r[0], 234);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/voice_env_pwm_mixer.md
# voice_env_pwm_mixer

Five-voice mixer sitting directly downstream of the five music units on the piano board. It takes each voice's square-wave bit and current tone index. It applies a per-voice retriggered linear-decay envelope, sums the five weighted voices, and drives the speaker pin with a single PWM bit. It also reports per-voice activity for the LED bar logic.

## Interface
Parameters:
- DECAY_DIV, default 2000: clock cycles between envelope decrement ticks. Legal range is 1..65535.
- PWM_PERIOD, default 1275: PWM frame length in cycles. Equals 5×255, the maximum sum.

Ports:
- CLK  in  1: system clock. This is the single clock for all logic.
- RST  in  1: reset, synchronous and active-high.
- EN  in  1: playback enable. Same signal that feeds the music units.
- WAVE  in  5: square-wave bit per voice. WAVE[i] belongs to voice i.
- TONES  in  35: tone indices, 7 bits per voice. Voice i is TONES[7i+6:7i]; value 0 means rest.
- PWM_OUT  out  1: mixed audio PWM bit.
- ACTIVE  out  5: ACTIVE[i]=1 while envelope i is nonzero.
- LEVEL  out  11: mix sample currently being played (0..1275).

## Operation
- Onset detect: per voice, a registered prev_tone (7b).
  - onset[i] = (TONES_i != prev_tone_i) && (TONES_i != 0).
  - prev_tone_i updates every cycle, regardless of EN.
- Envelope env_i (8b), updated in this priority order:
  1. If TONES_i == 0, env_i ← 0 (rest clears).
  2. Else if onset[i], env_i ← 255.
  3. Else if decay tick and env_i > 0 and EN, env_i ← env_i − 1. The envelope floors at 0 and never wraps.
  4. Otherwise env_i holds.
- Decay prescaler (16b):
  - Counts 0..DECAY_DIV−1 while EN=1; holds while EN=0.
  - Tick is asserted during the cycle when count == DECAY_DIV−1, after which the count wraps to 0.
  - With DECAY_DIV=1, tick is asserted every cycle.
- Mix: sum = Σ (WAVE[i] ? env_i : 0). Result is 11 bits unsigned with no saturation needed (max 1275). It is registered as mix_r.
- PWM:
  - Frame counter pc (11b) counts 0..PWM_PERIOD−1 and wraps. It runs regardless of EN.
  - At the wrap cycle (pc == PWM_PERIOD−1), LEVEL ← mix_r. LEVEL is stable for the whole frame.
  - PWM_OUT registered = EN && (pc_next < LEVEL_next). The next frame's first cycle uses the freshly latched LEVEL.
  - LEVEL=0 gives constant low; LEVEL=1275 gives constant high.
- ACTIVE[i] is registered as (env_i != 0).
- EN=0:
  - PWM_OUT forced 0.
  - Envelopes hold, except for rest-clear and onset, which still apply.
  - Prescaler frozen.

## Timing
- Reset (RST high at a CLK edge) sets all of the following to 0: env_i, prev_tone_i, prescaler, pc, mix_r, LEVEL, PWM_OUT, ACTIVE.
- RST asserted mid-note:
  - Everything is zeroed on that edge.
  - After release, a nonzero steady TONES_i counts as an onset in the first cycle, because prev_tone is 0. The voice therefore retriggers to 255.
- Latency from a TONES change:
  - Edge N: onset detected.
  - Edge N+1: env=255, ACTIVE=1 follows on the next edge.
  - Edge N+2: mix_r reflects the new env.
  - Next frame wrap: LEVEL latched.
  - Cycle after that: PWM_OUT reflects the new level.
- WAVE to mix_r latency is 1 cycle. WAVE changes within a frame affect LEVEL only at the next wrap.
- Same-cycle onset and decay tick: onset wins, env=255.
- Same-cycle rest and tick: env=0.
- Repeated identical nonzero tone: no retrigger.
- Tone change nonzero→different nonzero: retrigger.
- Full decay takes 255×DECAY_DIV enabled cycles from onset.

## Test plan
- Reset: RST held 3 cycles with WAVE=5'h1F and all tones 30 → all outputs 0 during reset. After release, all five env=255 and ACTIVE=5'h1F within 2 cycles.
- Single voice, DECAY_DIV=4, WAVE=5'b00001 constant, TONES_0 0→30:
  - ACTIVE[0]=1 two edges later.
  - First full frame after onset has LEVEL in 254..255 and exactly LEVEL high cycles out of 1275.
  - ACTIVE[0] falls 1020±4 cycles after onset.
- Full mix: all five voices onset together, WAVE=5'h1F → LEVEL=1275 and PWM_OUT high for every cycle of the frame. With WAVE=0, LEVEL=0 next frame and PWM_OUT constantly low.
- Retrigger rules, voice 2, DECAY_DIV=1:
  - Tone 40 held 100 cycles: env≈155, with no retrigger on the repeated value.
  - Change to 41: env=255 next cycle.
  - Change to 0: env=0 and ACTIVE[2]=0 within 2 cycles.
- Onset colliding with decay tick: align the TONES change with the prescaler tick → env=255, not 254.
- EN gating: EN=0 for 500 cycles mid-decay → PWM_OUT=0 and env unchanged. After EN=1, decay resumes from the held value.
